// File: rtl/sumador_monedas_display_if.sv
// Bus between the coin/credit controller and the vending-machine host:
// raw requests in, credit/change/status and the four display digits out.
interface sumador_monedas_display_if;
    logic [3:0]  moneda;
    logic        compra;
    logic        cancelar;
    logic [13:0] precio;
    logic [13:0] credito;
    logic        dispensar;
    logic [13:0] vuelto;
    logic        vuelto_valido;
    logic        rechazo;
    logic        insuficiente;
    logic        conv_busy;
    logic [6:0]  Segmentos0_Suma;
    logic [6:0]  Segmentos1_Suma;
    logic [6:0]  Segmentos2_Suma;
    logic [6:0]  Segmentos3_Suma;

    modport master (
        output moneda, compra, cancelar, precio,
        input  credito, dispensar, vuelto, vuelto_valido, rechazo, insuficiente,
        input  conv_busy, Segmentos0_Suma, Segmentos1_Suma, Segmentos2_Suma, Segmentos3_Suma
    );

    modport slave (
        input  moneda, compra, cancelar, precio,
        output credito, dispensar, vuelto, vuelto_valido, rechazo, insuficiente,
        output conv_busy, Segmentos0_Suma, Segmentos1_Suma, Segmentos2_Suma, Segmentos3_Suma
    );
endinterface

// File: rtl/sumador_monedas_display.sv
// Coin-credit accumulator with purchase/cancel resolution and a sequential
// double-dabble conversion feeding four active-low 7-segment digits.
module sumador_monedas_display #(
    parameter int VAL_M0      = 25,
    parameter int VAL_M1      = 50,
    parameter int VAL_M2      = 100,
    parameter int VAL_M3      = 500,
    parameter int MAX_CREDITO = 9975,
    parameter bit BLANK_CEROS = 1'b1
) (
    input logic clk,
    input logic rst_n,
    sumador_monedas_display_if.slave bus
);

    localparam logic [13:0] VAL0      = 14'(VAL_M0);
    localparam logic [13:0] VAL1      = 14'(VAL_M1);
    localparam logic [13:0] VAL2      = 14'(VAL_M2);
    localparam logic [13:0] VAL3      = 14'(VAL_M3);
    localparam logic [14:0] MAX15     = 15'(MAX_CREDITO);
    localparam logic [6:0]  SEG_BLANK = 7'b1111111;
    localparam logic [6:0]  SEG_CERO  = 7'b0000001;
    localparam logic [6:0]  SEG_ALTO_RESET = BLANK_CEROS ? SEG_BLANK : SEG_CERO;

    typedef enum logic [1:0] {IDLE, CARGA, DESPLAZA, ACTUALIZA} estado_t;

    // Bit layout of the request vectors: [3:0] moneda, [4] compra, [5] cancelar.
    logic [5:0]  sync1_q, sync2_q, prev_q;
    logic [5:0]  evento;

    logic [13:0] credito_q, credito_d;
    logic [13:0] vuelto_q, vuelto_d;
    logic        dispensar_q, dispensar_d;
    logic        vv_q, vv_d;
    logic        rechazo_q, rechazo_d;
    logic        insuf_q, insuf_d;

    logic [13:0] valMoneda;
    logic        varias;
    logic [14:0] suma;

    estado_t     estado_q;
    logic [13:0] bin_q;
    logic [15:0] bcd_q;
    logic [15:0] bcdAjustado;
    logic [3:0]  cuenta_q;
    logic        busy_q;
    logic [6:0]  seg0_q, seg1_q, seg2_q, seg3_q;
    logic        cambio;
    logic [3:0]  dig0, dig1, dig2, dig3;
    logic        blank1, blank2, blank3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= {bus.cancelar, bus.compra, bus.moneda};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign evento = sync2_q & ~prev_q;

    // Only the most valuable of simultaneous coins is credited.
    always_comb begin
        valMoneda = '0;
        varias    = 1'b0;
        casez (evento[3:0])
            4'b1???: begin valMoneda = VAL3; varias = |evento[2:0]; end
            4'b01??: begin valMoneda = VAL2; varias = |evento[1:0]; end
            4'b001?: begin valMoneda = VAL1; varias = evento[0];    end
            4'b0001: begin valMoneda = VAL0; varias = 1'b0;         end
            default: begin valMoneda = '0;   varias = 1'b0;         end
        endcase
    end

    assign suma = {1'b0, credito_q} + {1'b0, valMoneda};

    always_comb begin
        credito_d   = credito_q;
        vuelto_d    = vuelto_q;
        dispensar_d = 1'b0;
        vv_d        = 1'b0;
        rechazo_d   = 1'b0;
        insuf_d     = 1'b0;
        if (evento[5]) begin
            vuelto_d  = credito_q;
            vv_d      = 1'b1;
            credito_d = '0;
            rechazo_d = |evento[3:0];
        end else if (evento[4]) begin
            if (credito_q >= bus.precio) begin
                dispensar_d = 1'b1;
                vv_d        = 1'b1;
                vuelto_d    = credito_q - bus.precio;
                credito_d   = '0;
            end else begin
                insuf_d = 1'b1;
            end
            rechazo_d = |evento[3:0];
        end else if (|evento[3:0]) begin
            rechazo_d = varias;
            if (suma <= MAX15) begin
                credito_d = suma[13:0];
            end else begin
                rechazo_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credito_q   <= '0;
            vuelto_q    <= '0;
            dispensar_q <= 1'b0;
            vv_q        <= 1'b0;
            rechazo_q   <= 1'b0;
            insuf_q     <= 1'b0;
        end else begin
            credito_q   <= credito_d;
            vuelto_q    <= vuelto_d;
            dispensar_q <= dispensar_d;
            vv_q        <= vv_d;
            rechazo_q   <= rechazo_d;
            insuf_q     <= insuf_d;
        end
    end

    assign cambio = (credito_d != credito_q);

    always_comb begin
        bcdAjustado = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcdAjustado[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    assign dig0   = bcd_q[3:0];
    assign dig1   = bcd_q[7:4];
    assign dig2   = bcd_q[11:8];
    assign dig3   = bcd_q[15:12];
    assign blank3 = BLANK_CEROS && (dig3 == 4'd0);
    assign blank2 = blank3 && (dig2 == 4'd0);
    assign blank1 = blank2 && (dig1 == 4'd0);

    function automatic logic [6:0] codigo7(input logic [3:0] d);
        case (d)
            4'd0:    codigo7 = 7'b0000001;
            4'd1:    codigo7 = 7'b1001111;
            4'd2:    codigo7 = 7'b0010010;
            4'd3:    codigo7 = 7'b0000110;
            4'd4:    codigo7 = 7'b1001100;
            4'd5:    codigo7 = 7'b0100100;
            4'd6:    codigo7 = 7'b0100000;
            4'd7:    codigo7 = 7'b0001111;
            4'd8:    codigo7 = 7'b0000000;
            4'd9:    codigo7 = 7'b0000100;
            default: codigo7 = SEG_BLANK;
        endcase
    endfunction

    // A credit change always wins: any conversion in flight is dropped and the
    // old digits stay up until a clean conversion of the newest value finishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= IDLE;
            bin_q    <= '0;
            bcd_q    <= '0;
            cuenta_q <= '0;
            busy_q   <= 1'b0;
            seg0_q   <= SEG_CERO;
            seg1_q   <= SEG_ALTO_RESET;
            seg2_q   <= SEG_ALTO_RESET;
            seg3_q   <= SEG_ALTO_RESET;
        end else if (cambio) begin
            estado_q <= CARGA;
        end else begin
            case (estado_q)
                IDLE: begin
                    busy_q <= 1'b0;
                end
                CARGA: begin
                    bin_q    <= credito_q;
                    bcd_q    <= '0;
                    cuenta_q <= '0;
                    busy_q   <= 1'b1;
                    estado_q <= DESPLAZA;
                end
                DESPLAZA: begin
                    {bcd_q, bin_q} <= {bcdAjustado[14:0], bin_q, 1'b0};
                    cuenta_q       <= cuenta_q + 4'd1;
                    if (cuenta_q == 4'd13) begin
                        estado_q <= ACTUALIZA;
                    end
                end
                ACTUALIZA: begin
                    seg0_q   <= codigo7(dig0);
                    seg1_q   <= blank1 ? SEG_BLANK : codigo7(dig1);
                    seg2_q   <= blank2 ? SEG_BLANK : codigo7(dig2);
                    seg3_q   <= blank3 ? SEG_BLANK : codigo7(dig3);
                    estado_q <= IDLE;
                end
                default: begin
                    estado_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.credito         = credito_q;
    assign bus.dispensar       = dispensar_q;
    assign bus.vuelto          = vuelto_q;
    assign bus.vuelto_valido   = vv_q;
    assign bus.rechazo         = rechazo_q;
    assign bus.insuficiente    = insuf_q;
    assign bus.conv_busy       = busy_q;
    assign bus.Segmentos0_Suma = seg0_q;
    assign bus.Segmentos1_Suma = seg1_q;
    assign bus.Segmentos2_Suma = seg2_q;
    assign bus.Segmentos3_Suma = seg3_q;

endmodule

// File: tb/tb_sumador_monedas_display.sv
// Directed bench for the coin-credit accumulator: a reference model predicts each
// request's outcome into a queue, which is popped when the DUT's result lands.
module tb_sumador_monedas_display;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    sumador_monedas_display_if bus ();

    sumador_monedas_display #(
        .VAL_M0(25), .VAL_M1(50), .VAL_M2(100), .VAL_M3(500),
        .MAX_CREDITO(9975), .BLANK_CEROS(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        int credito;
        int vuelto;
        bit vv;
        bit disp;
        bit rech;
        bit insuf;
    } expT;

    expT         sb[$];
    int          total = 0;
    int          failures = 0;
    int          modelCredito = 0;
    int          modelVuelto = 0;
    logic [27:0] segsVisible;
    logic [27:0] segsReset;
    logic [6:0]  segTab [10];

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, expv, expv);
        end
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [27:0] obsSegs();
        return {bus.Segmentos3_Suma, bus.Segmentos2_Suma, bus.Segmentos1_Suma, bus.Segmentos0_Suma};
    endfunction

    function automatic logic [27:0] segsDe(input int c);
        logic [6:0] s [4];
        int         d [4];
        d[0] = c % 10;
        d[1] = (c / 10) % 10;
        d[2] = (c / 100) % 10;
        d[3] = (c / 1000) % 10;
        for (int k = 0; k < 4; k++) s[k] = segTab[d[k]];
        if (c < 1000) s[3] = 7'b1111111;
        if (c < 100)  s[2] = 7'b1111111;
        if (c < 10)   s[1] = 7'b1111111;
        return {s[3], s[2], s[1], s[0]};
    endfunction

    task automatic applyStimulus(input logic [3:0] m, input bit c, input bit k, input int p);
        expT e;
        int  val;
        bus.precio = 14'(p);
        e.vv = 1'b0; e.disp = 1'b0; e.rech = 1'b0; e.insuf = 1'b0;
        if (k) begin
            e.vv = 1'b1;
            modelVuelto = modelCredito;
            modelCredito = 0;
            e.rech = (m != 4'b0);
        end else if (c) begin
            if (modelCredito >= p) begin
                e.disp = 1'b1;
                e.vv = 1'b1;
                modelVuelto = modelCredito - p;
                modelCredito = 0;
            end else begin
                e.insuf = 1'b1;
            end
            e.rech = (m != 4'b0);
        end else if (m != 4'b0) begin
            val = m[3] ? 500 : m[2] ? 100 : m[1] ? 50 : 25;
            e.rech = ($countones(m) > 1);
            if (modelCredito + val > 9975) e.rech = 1'b1;
            else modelCredito = modelCredito + val;
        end
        e.credito = modelCredito;
        e.vuelto = modelVuelto;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bus.moneda = m;
        bus.compra = c;
        bus.cancelar = k;
        repeat (3) @(posedge clk);
        #1;
        bus.moneda = 4'b0;
        bus.compra = 1'b0;
        bus.cancelar = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        expT e;
        total++;
        assert (sb.size() != 0) else begin
            failures++;
            $error("[TB] FAIL %s/queue: observed 0 entries expected at least 1", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checkVal({tag, "/credito"}, 32'(bus.credito), 32'(e.credito));
            checkVal({tag, "/vuelto"}, 32'(bus.vuelto), 32'(e.vuelto));
            checkVal({tag, "/vuelto_valido"}, 32'(bus.vuelto_valido), 32'(e.vv));
            checkVal({tag, "/dispensar"}, 32'(bus.dispensar), 32'(e.disp));
            checkVal({tag, "/rechazo"}, 32'(bus.rechazo), 32'(e.rech));
            checkVal({tag, "/insuficiente"}, 32'(bus.insuficiente), 32'(e.insuf));
        end
    endtask

    // Called right after checkOutput; walks the 17 edges following a result.
    task automatic settle(input string tag, input bit cambia);
        logic [27:0] previo;
        logic [27:0] nuevo;
        previo = segsVisible;
        nuevo = segsDe(modelCredito);
        waitEdges(1);
        checkVal({tag, "/pulsos_1ciclo"},
                 32'({bus.dispensar, bus.vuelto_valido, bus.rechazo, bus.insuficiente}), 32'(0));
        if (cambia) begin
            checkVal({tag, "/busy_t1"}, 32'(bus.conv_busy), 32'(1));
            for (int i = 2; i <= 16; i++) begin
                waitEdges(1);
                checkVal({tag, "/busy_run"}, 32'(bus.conv_busy), 32'(1));
                if (i == 15) checkVal({tag, "/segs_t15_old"}, 32'(obsSegs()), 32'(previo));
            end
            checkVal({tag, "/segs_t16_new"}, 32'(obsSegs()), 32'(nuevo));
            waitEdges(1);
            checkVal({tag, "/busy_t17"}, 32'(bus.conv_busy), 32'(0));
            segsVisible = nuevo;
        end else begin
            checkVal({tag, "/busy_idle"}, 32'(bus.conv_busy), 32'(0));
            waitEdges(16);
            checkVal({tag, "/segs_held"}, 32'(obsSegs()), 32'(previo));
            checkVal({tag, "/busy_idle_end"}, 32'(bus.conv_busy), 32'(0));
        end
    endtask

    task automatic checkResetState(input string tag);
        checkVal({tag, "/credito"}, 32'(bus.credito), 32'(0));
        checkVal({tag, "/vuelto"}, 32'(bus.vuelto), 32'(0));
        checkVal({tag, "/pulsos"},
                 32'({bus.dispensar, bus.vuelto_valido, bus.rechazo, bus.insuficiente}), 32'(0));
        checkVal({tag, "/busy"}, 32'(bus.conv_busy), 32'(0));
        checkVal({tag, "/segs"}, 32'(obsSegs()), 32'(segsReset));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no end of test, expected finish before 200000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        segTab[0] = 7'b0000001; segTab[1] = 7'b1001111; segTab[2] = 7'b0010010;
        segTab[3] = 7'b0000110; segTab[4] = 7'b1001100; segTab[5] = 7'b0100100;
        segTab[6] = 7'b0100000; segTab[7] = 7'b0001111; segTab[8] = 7'b0000000;
        segTab[9] = 7'b0000100;
        segsReset = {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001};
        segsVisible = segsReset;

        bus.moneda = 4'b0;
        bus.compra = 1'b0;
        bus.cancelar = 1'b0;
        bus.precio = 14'd0;
        rst_n = 1'b0;
        waitEdges(3);
        checkResetState("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        waitEdges(4);
        checkResetState("reset_released");

        $display("[TB] coins 100 then 500");
        applyStimulus(4'b0100, 1'b0, 1'b0, 0);
        checkOutput("moneda2");
        settle("moneda2", 1'b1);
        waitEdges(5);
        applyStimulus(4'b1000, 1'b0, 1'b0, 0);
        checkOutput("moneda3");
        settle("moneda3", 1'b1);
        checkVal("segs_600_literal", 32'(obsSegs()),
                 32'({7'b1111111, 7'b0100000, 7'b0000001, 7'b0000001}));

        $display("[TB] purchase with change, then refused purchase");
        applyStimulus(4'b0000, 1'b1, 1'b0, 350);
        checkOutput("compra_ok");
        checkVal("vuelto_250_literal", 32'(bus.vuelto), 32'(250));
        settle("compra_ok", 1'b1);
        applyStimulus(4'b0100, 1'b0, 1'b0, 350);
        checkOutput("recarga100");
        settle("recarga100", 1'b1);
        applyStimulus(4'b0000, 1'b1, 1'b0, 350);
        checkOutput("compra_insuf");
        settle("compra_insuf", 1'b0);

        $display("[TB] filling credit up to the ceiling");
        for (int i = 0; i < 23; i++) begin
            applyStimulus(i < 19 ? 4'b1000 : (i < 22 ? 4'b0100 : 4'b0010), 1'b0, 1'b0, 0);
            checkOutput("relleno");
        end
        settle("relleno_9950", 1'b1);
        applyStimulus(4'b0010, 1'b0, 1'b0, 0);
        checkOutput("tope_rechazo");
        settle("tope_rechazo", 1'b0);
        applyStimulus(4'b0001, 1'b0, 1'b0, 0);
        checkOutput("tope_9975");
        settle("tope_9975", 1'b1);
        checkVal("segs_9975_literal", 32'(obsSegs()),
                 32'({7'b0000100, 7'b0000100, 7'b0001111, 7'b0100100}));

        applyStimulus(4'b0000, 1'b1, 1'b0, 0);
        checkOutput("compra_precio0");
        settle("compra_precio0", 1'b1);

        $display("[TB] same-cycle edges");
        applyStimulus(4'b0100, 1'b0, 1'b0, 0);
        checkOutput("carga_a");
        applyStimulus(4'b0100, 1'b0, 1'b0, 0);
        checkOutput("carga_b");
        settle("carga_200", 1'b1);
        applyStimulus(4'b1001, 1'b0, 1'b1, 0);
        checkOutput("cancel_con_monedas");
        settle("cancel_con_monedas", 1'b1);
        applyStimulus(4'b0101, 1'b0, 1'b0, 0);
        checkOutput("dos_monedas");
        settle("dos_monedas", 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b1, 0);
        checkOutput("cancel_100");
        settle("cancel_100", 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b1, 0);
        checkOutput("cancel_vacio");
        settle("cancel_vacio", 1'b0);

        $display("[TB] conversion restart and reset mid-conversion");
        applyStimulus(4'b0100, 1'b0, 1'b0, 0);
        checkOutput("restart_a");
        waitEdges(1);
        checkVal("restart_busy_t1", 32'(bus.conv_busy), 32'(1));
        applyStimulus(4'b0001, 1'b0, 1'b0, 0);
        checkOutput("restart_b");
        checkVal("restart_busy_at_b", 32'(bus.conv_busy), 32'(1));
        checkVal("restart_segs_old", 32'(obsSegs()), 32'(segsVisible));
        settle("restart_b", 1'b1);

        applyStimulus(4'b1000, 1'b0, 1'b0, 0);
        checkOutput("pre_reset");
        waitEdges(5);
        rst_n = 1'b0;
        #1;
        modelCredito = 0;
        modelVuelto = 0;
        segsVisible = segsReset;
        checkResetState("reset_mid_conv");
        @(negedge clk);
        rst_n = 1'b1;
        waitEdges(20);
        checkResetState("post_reset_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", total, failures);
        $finish;
    end

endmodule

// File: doc/sumador_monedas_display.md
Name: sumador_monedas_display

Overview:
- Coin-credit accumulator for the coffee vending machine; directly upstream of the 4-digit display multiplexer.
- Detects coin inserts and accumulates credit in binary.
- Resolves purchase and cancel requests, computing change.
- Converts credit to BCD sequentially and drives Segmentos0_Suma..Segmentos3_Suma: active-low 7-segment codes, bit6=a … bit0=g, digit0 = units.

Parameters:
- VAL_M0, 25, value of coin input moneda[0]
- VAL_M1, 50, value of coin input moneda[1]
- VAL_M2, 100, value of coin input moneda[2]
- VAL_M3, 500, value of coin input moneda[3]
- MAX_CREDITO, 9975, highest credit accepted; must be ≤ 9999
- BLANK_CEROS, 1, 1 = leading-zero digits 3..1 blanked; digit0 is never blanked

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- moneda  in  4  raw coin-sensor levels, asynchronous
- compra  in  1  purchase request level, asynchronous
- cancelar  in  1  cancel/refund request level, asynchronous
- precio  in  14  selected drink price, binary, synchronous, stable
- credito  out  14  current credit, binary
- dispensar  out  1  one-cycle pulse: purchase accepted
- vuelto  out  14  change amount, valid while vuelto_valido=1
- vuelto_valido  out  1  one-cycle pulse
- rechazo  out  1  one-cycle pulse: coin dropped
- insuficiente  out  1  one-cycle pulse: purchase refused
- conv_busy  out  1  BCD conversion in progress
- Segmentos0_Suma..Segmentos3_Suma  out  7 each  active-low segment codes

Behaviour:
- Reset (async assert, sync release):
  - credito=0, vuelto=0, all pulses=0, conv_busy=0.
  - Segmentos0_Suma=7'b0000001 ("0").
  - Segmentos1..3_Suma = 7'b1111111 if BLANK_CEROS=1, else "0".
  - Synchronizers and edge registers clear.
- Inputs: moneda, compra, cancelar each pass through 2-FF synchronizer plus previous-value register. An event is a rising edge (sync2 & ~prev). Result: effect is registered 3 clk edges after the input is first sampled high. Held levels produce one event only.
- Per-cycle priority: cancelar > compra > moneda. Lower-priority events in the same cycle are discarded. A discarded coin pulses rechazo.
- Multiple coin edges in one cycle: highest-value coin processed; others dropped, rechazo=1.
- Coin: if credito+VAL ≤ MAX_CREDITO then credito += VAL; else credito unchanged and rechazo=1.
- Compra:
  - If credito ≥ precio: dispensar=1, vuelto=credito-precio, vuelto_valido=1, credito=0 (same edge).
  - Else: insuficiente=1, credito unchanged.
  - precio=0 is legal: dispenses, vuelto=credito.
- Cancelar: vuelto=credito, vuelto_valido=1, credito=0. If credito=0: vuelto_valido=1 with vuelto=0.
- vuelto holds its value until the next vuelto_valido.
- Pulses are exactly one cycle and never repeat without a new edge.
- BCD conversion FSM states: IDLE, CARGA, DESPLAZA, ACTUALIZA.
  - Any edge T that changes credito causes CARGA at T+1: snapshot credito, conv_busy=1.
  - DESPLAZA: 14 double-dabble iterations (add-3 if nibble ≥5, then shift), edges T+2..T+15.
  - ACTUALIZA at T+16: segments registered, conv_busy=0 from T+17.
  - Net: segments reflect a new credito 16 edges after it changes; old digits are held meanwhile.
- Credito changing during conversion: current conversion aborted, CARGA re-entered next cycle, segments never show a stale intermediate.
- No credito change: FSM stays IDLE, conv_busy=0.
- Encoding, active-low abcdefg:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - blank=1111111
- Blanking (BLANK_CEROS=1): digit k, k≥1, is blank iff it and all higher digits are 0.
- Reset mid-conversion: immediate return to reset values; no partial display update.

Test Plan:
- Reset, no stimulus → segments {blank,blank,blank,"0"}; credito=0; conv_busy=0.
- Pulse moneda[2] then moneda[3], ≥20 cycles apart:
  - credito 100 then 600.
  - Segments {blank,"6","0","0"} = {1111111,0100000,0000001,0000001}.
  - Each update lands exactly 16 edges after the credito change.
- Credit 9950, insert moneda[1] (50) → rechazo=1, credito stays 9950. Insert moneda[0] → credito 9975; display "9975".
- Credit 600, precio=350, compra → dispensar=1, vuelto=250, vuelto_valido=1, credito=0; display returns to blank,blank,blank,"0". Then credit 100, precio=350, compra → insuficiente=1, credito=100.
- Same-cycle edges:
  - moneda[0], moneda[3] and cancelar rising together with credit 200 → vuelto=200, credito=0, rechazo=1, no coin added.
  - moneda[0]+moneda[2] together → credito +100, rechazo=1.
- Coin inserted 5 cycles into a conversion → conversion restarts; conv_busy stays high continuously; final segments match the final credito only. rst_n low mid-conversion → reset values immediately.
